// File: rtl/rf_arb_pkg.sv
// rf_arb_pkg: widths, FSM states and requester ids shared by the register-file port arbiter.
package rf_arb_pkg;

   localparam int DATA_W_DEF = 8;
   localparam int ADDR_W_DEF = 2;

   typedef enum logic {
      NORMAL = 1'b0,
      LOCKED = 1'b1
   } arb_state_e;

   typedef enum logic {
      REQ_CU  = 1'b0,
      REQ_DBG = 1'b1
   } req_id_e;

endpackage

// File: rtl/rf_port_arbiter_if.sv
// rf_port_arbiter_if: one requester's valid/ready request channel plus its fixed-latency read response.
interface rf_port_arbiter_if
   import rf_arb_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int ADDR_W = ADDR_W_DEF
);

   logic              req_valid;
   logic              req_ready;
   logic              req_we;
   logic [ADDR_W-1:0] req_addr;
   logic [DATA_W-1:0] req_wdata;
   logic              rsp_valid;
   logic [DATA_W-1:0] rsp_rdata;

   modport master (
      output req_valid, req_we, req_addr, req_wdata,
      input  req_ready, rsp_valid, rsp_rdata
   );

   modport slave (
      input  req_valid, req_we, req_addr, req_wdata,
      output req_ready, rsp_valid, rsp_rdata
   );

endinterface

// File: rtl/rf_arb_pick.sv
// rf_arb_pick: combinational two-way grant; a ready never looks at its own requester's valid.
// RF_ARB_RR_EN selects round-robin on collision; otherwise the CU always wins.
module rf_arb_pick
   import rf_arb_pkg::*;
(
   input  logic    i_cu_valid,
   input  logic    i_dbg_valid,
   input  logic    i_locked,
`ifdef RF_ARB_RR_EN
   input  req_id_e i_last,
`endif
   output logic    o_cu_ready,
   output logic    o_dbg_ready
);

   logic w_cu_wins;

`ifdef RF_ARB_RR_EN
   assign w_cu_wins = (i_last == REQ_DBG);
`else
   assign w_cu_wins = 1'b1;
`endif

   assign o_cu_ready  = ~i_locked & (~i_dbg_valid | w_cu_wins);
   assign o_dbg_ready =  i_locked | ~i_cu_valid | ~w_cu_wins;

endmodule

// File: rtl/rf_port_arbiter.sv
// rf_port_arbiter: shares the register-file port between CU and DBG with a DBG lock handshake.
// Optional feature macro: RF_ARB_RR_EN (round-robin collisions); undefined gives fixed CU priority.
module rf_port_arbiter
   import rf_arb_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int ADDR_W = ADDR_W_DEF
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   rf_port_arbiter_if.slave  cu,
   rf_port_arbiter_if.slave  dbg,
   input  logic              i_dbg_lock,
   output logic              o_dbg_lock_ack,
   output logic              o_rf_we,
   output logic [ADDR_W-1:0] o_rf_addr,
   output logic [DATA_W-1:0] o_rf_wdata,
   input  logic [DATA_W-1:0] i_rf_rdata
);

   arb_state_e        r_state;
   logic              r_rf_we;
   logic [ADDR_W-1:0] r_rf_addr;
   logic [DATA_W-1:0] r_rf_wdata;
   logic              r_rd_pend;
   req_id_e           r_rd_tag;
   logic              r_cu_rsp_valid;
   logic              r_dbg_rsp_valid;
   logic [DATA_W-1:0] r_cu_rsp_rdata;
   logic [DATA_W-1:0] r_dbg_rsp_rdata;
`ifdef RF_ARB_RR_EN
   req_id_e           r_last;
`endif

   logic              w_locked;
   logic              w_cu_ready;
   logic              w_dbg_ready;
   logic              w_cu_fire;
   logic              w_dbg_fire;
   logic              w_fire;
   logic              w_sel_we;
   logic [ADDR_W-1:0] w_sel_addr;
   logic [DATA_W-1:0] w_sel_wdata;

   assign w_locked = (r_state == LOCKED);

   rf_arb_pick u_pick (
      .i_cu_valid  (cu.req_valid),
      .i_dbg_valid (dbg.req_valid),
      .i_locked    (w_locked),
`ifdef RF_ARB_RR_EN
      .i_last      (r_last),
`endif
      .o_cu_ready  (w_cu_ready),
      .o_dbg_ready (w_dbg_ready)
   );

   // The grants are mutually exclusive whenever both are valid, so at most one fire per cycle.
   assign w_cu_fire  = cu.req_valid  & w_cu_ready;
   assign w_dbg_fire = dbg.req_valid & w_dbg_ready;
   assign w_fire     = w_cu_fire | w_dbg_fire;

   assign w_sel_we    = w_dbg_fire ? dbg.req_we    : cu.req_we;
   assign w_sel_addr  = w_dbg_fire ? dbg.req_addr  : cu.req_addr;
   assign w_sel_wdata = w_dbg_fire ? dbg.req_wdata : cu.req_wdata;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state         <= NORMAL;
         r_rf_we         <= 1'b0;
         r_rf_addr       <= '0;
         r_rf_wdata      <= '0;
         r_rd_pend       <= 1'b0;
         r_rd_tag        <= REQ_CU;
         r_cu_rsp_valid  <= 1'b0;
         r_dbg_rsp_valid <= 1'b0;
         r_cu_rsp_rdata  <= '0;
         r_dbg_rsp_rdata <= '0;
`ifdef RF_ARB_RR_EN
         r_last          <= REQ_DBG;
`endif
      end else begin
         case (r_state)
            NORMAL:  if (i_dbg_lock)  r_state <= LOCKED;
            LOCKED:  if (!i_dbg_lock) r_state <= NORMAL;
            default: r_state <= NORMAL;
         endcase

         // Stage 1: drive the RF port for the access accepted this cycle.
         r_rf_we   <= w_fire & w_sel_we;
         r_rd_pend <= w_fire & ~w_sel_we;
         if (w_fire) begin
            r_rf_addr <= w_sel_addr;
            r_rd_tag  <= w_dbg_fire ? REQ_DBG : REQ_CU;
            if (w_sel_we) begin
               r_rf_wdata <= w_sel_wdata;
            end
`ifdef RF_ARB_RR_EN
            r_last <= w_dbg_fire ? REQ_DBG : REQ_CU;
`endif
         end

         // Stage 2: steer the RF read data back to the requester that issued the read.
         r_cu_rsp_valid  <= r_rd_pend & (r_rd_tag == REQ_CU);
         r_dbg_rsp_valid <= r_rd_pend & (r_rd_tag == REQ_DBG);
         if (r_rd_pend && r_rd_tag == REQ_CU) begin
            r_cu_rsp_rdata <= i_rf_rdata;
         end
         if (r_rd_pend && r_rd_tag == REQ_DBG) begin
            r_dbg_rsp_rdata <= i_rf_rdata;
         end
      end
   end

   assign cu.req_ready    = w_cu_ready;
   assign dbg.req_ready   = w_dbg_ready;
   assign cu.rsp_valid    = r_cu_rsp_valid;
   assign cu.rsp_rdata    = r_cu_rsp_rdata;
   assign dbg.rsp_valid   = r_dbg_rsp_valid;
   assign dbg.rsp_rdata   = r_dbg_rsp_rdata;
   assign o_dbg_lock_ack  = w_locked;
   assign o_rf_we         = r_rf_we;
   assign o_rf_addr       = r_rf_addr;
   assign o_rf_wdata      = r_rf_wdata;

endmodule

// File: tb/tb_rf_port_arbiter.sv
// tb_rf_port_arbiter: directed vector table, lock/reset sequences and a randomized run against a register model.
`timescale 1ns/1ps
module tb_rf_port_arbiter;
   import rf_arb_pkg::*;

`ifdef RF_ARB_RR_EN
   localparam bit RR = 1'b1;
`else
   localparam bit RR = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst_n;
   logic       dbg_lock;
   logic       dbg_lock_ack;
   logic       rf_we;
   logic [1:0] rf_addr;
   logic [7:0] rf_wdata;
   logic [7:0] rf_rdata;

   rf_port_arbiter_if cu_if ();
   rf_port_arbiter_if dbg_if ();

   always #5 clk = ~clk;

   rf_port_arbiter dut (
      .i_clk          (clk),
      .i_rst_n        (rst_n),
      .cu             (cu_if),
      .dbg            (dbg_if),
      .i_dbg_lock     (dbg_lock),
      .o_dbg_lock_ack (dbg_lock_ack),
      .o_rf_we        (rf_we),
      .o_rf_addr      (rf_addr),
      .o_rf_wdata     (rf_wdata),
      .i_rf_rdata     (rf_rdata)
   );

   // Register file R0-R3 with asynchronous read
   logic [7:0] rf_mem [4];
   logic       rf_clr;
   always @(posedge clk) begin
      if (rf_clr) begin
         for (int i = 0; i < 4; i++) rf_mem[i] <= 8'h00;
      end else if (rf_we) begin
         rf_mem[rf_addr] <= rf_wdata;
      end
   end
   assign rf_rdata = rf_mem[rf_addr];

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic drive(input bit cv, input bit cwe, input bit [1:0] ca, input bit [7:0] cd,
                        input bit dv, input bit dwe, input bit [1:0] da, input bit [7:0] dd);
      cu_if.req_valid  = cv;
      cu_if.req_we     = cwe;
      cu_if.req_addr   = ca;
      cu_if.req_wdata  = cd;
      dbg_if.req_valid = dv;
      dbg_if.req_we    = dwe;
      dbg_if.req_addr  = da;
      dbg_if.req_wdata = dd;
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   typedef struct {
      bit cv; bit cwe; bit [1:0] ca; bit [7:0] cd;
      bit dv; bit dwe; bit [1:0] da; bit [7:0] dd;
      bit ecr; bit edr;
      bit ewe; bit [1:0] eaddr; bit [7:0] ewd;
      bit ecv; bit [7:0] ecd;
      bit edv; bit [7:0] edd;
   } vec_t;

   function automatic vec_t mk(bit cv, bit cwe, bit [1:0] ca, bit [7:0] cd,
                               bit dv, bit dwe, bit [1:0] da, bit [7:0] dd,
                               bit ecr, bit edr, bit ewe, bit [1:0] eaddr, bit [7:0] ewd,
                               bit ecv, bit [7:0] ecd, bit edv, bit [7:0] edd);
      vec_t v;
      v.cv = cv; v.cwe = cwe; v.ca = ca; v.cd = cd;
      v.dv = dv; v.dwe = dwe; v.da = da; v.dd = dd;
      v.ecr = ecr; v.edr = edr; v.ewe = ewe; v.eaddr = eaddr; v.ewd = ewd;
      v.ecv = ecv; v.ecd = ecd; v.edv = edv; v.edd = edd;
      return v;
   endfunction

   // Request-level model used by the randomized run
   logic [7:0] m_reg [4];
   bit         m_locked;
   req_id_e    m_last;
   typedef struct { logic [7:0] data; int due; } rsp_t;
   rsp_t       q_cu[$];
   rsp_t       q_dbg[$];

   function automatic bit granted(req_id_e me, bit other_valid);
      req_id_e winner;
      if (m_locked) return (me == REQ_DBG);
      if (!other_valid) return 1'b1;
      winner = REQ_CU;
      if (RR && m_last == REQ_CU) winner = REQ_DBG;
      return (winner == me);
   endfunction

   vec_t vecs [14];

   initial begin
      bit         cv, cwe, dv, dwe, lk, e_cr, e_dr, acc_cu, acc_dbg, exp_v;
      bit [1:0]   ca, da;
      bit [7:0]   cd, dd;
      logic [7:0] last_cu, last_dbg;
      rsp_t       e;

      // Cycle-by-cycle table from reset; rf_* reflect the previous cycle's accept, rsp the one two back.
      vecs[0]  = mk(1,1,2,8'h3C, 0,0,0,0,     1,0,    1'b0,0,0,     0,0,     0,0);
      vecs[1]  = mk(1,0,2,0,     0,0,0,0,     1,RR,   1'b1,2,8'h3C, 0,0,     0,0);
      vecs[2]  = mk(0,0,0,0,     1,1,1,8'h05, !RR,1,  1'b0,0,0,     0,0,     0,0);
      vecs[3]  = mk(1,0,1,0,     0,0,0,0,     1,0,    1'b1,1,8'h05, 1,8'h3C, 0,0);
      vecs[4]  = mk(0,0,0,0,     0,0,0,0,     1,1,    1'b0,0,0,     0,0,     0,0);
      vecs[5]  = mk(0,0,0,0,     0,0,0,0,     1,1,    1'b0,0,0,     1,8'h05, 0,0);
      vecs[6]  = mk(0,0,0,0,     1,0,0,0,     !RR,1,  1'b0,0,0,     0,0,     0,0);
      vecs[7]  = mk(1,0,0,0,     1,0,1,0,     1,0,    1'b0,0,0,     0,0,     0,0);
      vecs[8]  = mk(1,0,0,0,     1,0,1,0,     !RR,RR, 1'b0,0,0,     0,0,     1,8'h00);
      vecs[9]  = mk(1,0,0,0,     1,0,1,0,     1,0,    1'b0,0,0,     1,8'h00, 0,0);
      vecs[10] = mk(1,0,0,0,     1,0,1,0,     !RR,RR, 1'b0,0,0,     !RR,8'h00, RR,8'h05);
      vecs[11] = mk(0,0,0,0,     0,0,0,0,     1,1,    1'b0,0,0,     1,8'h00, 0,0);
      vecs[12] = mk(0,0,0,0,     0,0,0,0,     1,1,    1'b0,0,0,     !RR,8'h00, RR,8'h05);
      vecs[13] = mk(0,0,0,0,     0,0,0,0,     1,1,    1'b0,0,0,     0,0,     0,0);

      rst_n    = 1'b0;
      dbg_lock = 1'b0;
      rf_clr   = 1'b1;
      drive(0,0,0,0, 0,0,0,0);
      repeat (2) @(posedge clk);
      #1;
      rf_clr = 1'b0;
      check("reset_rf_we",     rf_we, 0);
      check("reset_rf_addr",   rf_addr, 0);
      check("reset_rf_wdata",  rf_wdata, 0);
      check("reset_lock_ack",  dbg_lock_ack, 0);
      check("reset_cu_rsp_v",  cu_if.rsp_valid, 0);
      check("reset_dbg_rsp_v", dbg_if.rsp_valid, 0);
      check("reset_cu_rdata",  cu_if.rsp_rdata, 0);
      check("reset_dbg_rdata", dbg_if.rsp_rdata, 0);
      @(negedge clk);
      rst_n = 1'b1;
      next_cycle();

      // Directed table
      for (int i = 0; i < 14; i++) begin
         drive(vecs[i].cv, vecs[i].cwe, vecs[i].ca, vecs[i].cd,
               vecs[i].dv, vecs[i].dwe, vecs[i].da, vecs[i].dd);
         @(negedge clk);
         $display("[TB] vec %0d cu_ready=%0b dbg_ready=%0b rf_we=%0b", i,
                  cu_if.req_ready, dbg_if.req_ready, rf_we);
         check($sformatf("v%0d_cu_ready", i),  cu_if.req_ready, vecs[i].ecr);
         check($sformatf("v%0d_dbg_ready", i), dbg_if.req_ready, vecs[i].edr);
         check($sformatf("v%0d_lock_ack", i),  dbg_lock_ack, 0);
         check($sformatf("v%0d_rf_we", i),     rf_we, vecs[i].ewe);
         if (vecs[i].ewe) begin
            check($sformatf("v%0d_rf_addr", i),  rf_addr, vecs[i].eaddr);
            check($sformatf("v%0d_rf_wdata", i), rf_wdata, vecs[i].ewd);
         end
         check($sformatf("v%0d_cu_rsp_v", i), cu_if.rsp_valid, vecs[i].ecv);
         if (vecs[i].ecv) check($sformatf("v%0d_cu_rdata", i), cu_if.rsp_rdata, vecs[i].ecd);
         check($sformatf("v%0d_dbg_rsp_v", i), dbg_if.rsp_valid, vecs[i].edv);
         if (vecs[i].edv) check($sformatf("v%0d_dbg_rdata", i), dbg_if.rsp_rdata, vecs[i].edd);
         next_cycle();
      end

      // Lock sequence: CU keeps reading R3 throughout
      drive(1,0,3,0, 0,0,0,0);
      dbg_lock = 1'b1;
      @(negedge clk);
      $display("[TB] lock L0 lock raised, CU read R3");
      check("L0_lock_ack", dbg_lock_ack, 0);
      check("L0_cu_ready", cu_if.req_ready, 1);
      next_cycle();
      drive(1,0,3,0, 1,1,0,8'h0A);
      @(negedge clk);
      $display("[TB] lock L1 DBG write R0=0x0a");
      check("L1_lock_ack",  dbg_lock_ack, 1);
      check("L1_cu_ready",  cu_if.req_ready, 0);
      check("L1_dbg_ready", dbg_if.req_ready, 1);
      next_cycle();
      drive(1,0,3,0, 0,0,0,0);
      @(negedge clk);
      $display("[TB] lock L2 CU held");
      check("L2_lock_ack",  dbg_lock_ack, 1);
      check("L2_cu_ready",  cu_if.req_ready, 0);
      check("L2_dbg_ready", dbg_if.req_ready, 1);
      check("L2_rf_we",     rf_we, 1);
      check("L2_rf_addr",   rf_addr, 0);
      check("L2_rf_wdata",  rf_wdata, 8'h0A);
      check("L2_cu_rsp_v",  cu_if.rsp_valid, 1);
      check("L2_cu_rdata",  cu_if.rsp_rdata, 8'h00);
      next_cycle();
      dbg_lock = 1'b0;
      drive(1,0,3,0, 1,0,0,0);
      @(negedge clk);
      $display("[TB] lock L3 lock dropped, DBG read R0");
      check("L3_lock_ack", dbg_lock_ack, 1);
      check("L3_cu_ready", cu_if.req_ready, 0);
      check("L3_rf_we",    rf_we, 0);
      next_cycle();
      drive(1,0,3,0, 0,0,0,0);
      @(negedge clk);
      $display("[TB] lock L4 back to normal");
      check("L4_lock_ack", dbg_lock_ack, 0);
      check("L4_cu_ready", cu_if.req_ready, 1);
      next_cycle();
      drive(0,0,0,0, 0,0,0,0);
      @(negedge clk);
      $display("[TB] lock L5 DBG response");
      check("L5_dbg_rsp_v", dbg_if.rsp_valid, 1);
      check("L5_dbg_rdata", dbg_if.rsp_rdata, 8'h0A);
      check("L5_cu_rsp_v",  cu_if.rsp_valid, 0);
      next_cycle();
      @(negedge clk);
      $display("[TB] lock L6 CU response");
      check("L6_cu_rsp_v",  cu_if.rsp_valid, 1);
      check("L6_cu_rdata",  cu_if.rsp_rdata, 8'h00);
      check("L6_dbg_rsp_v", dbg_if.rsp_valid, 0);
      next_cycle();

      // Reset while a DBG write of 0xFF to R2 is in flight
      drive(0,0,0,0, 1,1,2,8'hFF);
      @(negedge clk);
      $display("[TB] reset-inflight DBG write R2=0xff");
      check("RI_dbg_ready", dbg_if.req_ready, 1);
      next_cycle();
      drive(0,0,0,0, 0,0,0,0);
      check("RI_inflight_we", rf_we, 1);
      #2;
      rst_n = 1'b0;
      #1;
      check("RI_rf_we",      rf_we, 0);
      check("RI_rf_addr",    rf_addr, 0);
      check("RI_rf_wdata",   rf_wdata, 0);
      check("RI_cu_rsp_v",   cu_if.rsp_valid, 0);
      check("RI_dbg_rsp_v",  dbg_if.rsp_valid, 0);
      check("RI_lock_ack",   dbg_lock_ack, 0);
      check("RI_dbg_rdata",  dbg_if.rsp_rdata, 0);
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check($sformatf("RI_post%0d_rf_we", i),     rf_we, 0);
         check($sformatf("RI_post%0d_cu_rsp_v", i),  cu_if.rsp_valid, 0);
         check($sformatf("RI_post%0d_dbg_rsp_v", i), dbg_if.rsp_valid, 0);
      end
      next_cycle();
      drive(1,0,2,0, 0,0,0,0);
      @(negedge clk);
      $display("[TB] reset-inflight CU read R2");
      next_cycle();
      drive(0,0,0,0, 0,0,0,0);
      @(negedge clk);
      next_cycle();
      @(negedge clk);
      check("RI_no_write_rsp_v", cu_if.rsp_valid, 1);
      check("RI_no_write_rdata", cu_if.rsp_rdata, 8'h3C);
      next_cycle();

      // Randomized run from a fresh reset
      rst_n = 1'b0;
      next_cycle();
      @(negedge clk);
      rst_n = 1'b1;
      next_cycle();
      m_locked = 1'b0;
      m_last   = REQ_DBG;
      for (int i = 0; i < 4; i++) m_reg[i] = 8'h00;
      last_cu  = 8'h00;
      last_dbg = 8'h00;
      lk       = 1'b0;
      for (int k = 0; k < 208; k++) begin
         if (k < 4) begin
            cv = 0; cwe = 0; ca = 0; cd = 0;
            dv = 1; dwe = 1; da = 2'(k); dd = 8'($urandom);
         end else if (k < 204) begin
            cv  = ($urandom_range(0, 3) != 0);
            dv  = ($urandom_range(0, 1) != 0);
            cwe = ($urandom_range(0, 1) != 0);
            dwe = ($urandom_range(0, 1) != 0);
            ca  = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 3)) : 2'($urandom_range(0, 1));
            da  = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 3)) : 2'($urandom_range(0, 1));
            cd  = 8'($urandom);
            dd  = 8'($urandom);
            if ($urandom_range(0, 15) == 0) lk = ~lk;
         end else begin
            cv = 0; cwe = 0; ca = 0; cd = 0;
            dv = 0; dwe = 0; da = 0; dd = 0;
            lk = 1'b0;
         end
         drive(cv, cwe, ca, cd, dv, dwe, da, dd);
         dbg_lock = lk;
         e_cr = granted(REQ_CU, dv);
         e_dr = granted(REQ_DBG, cv);
         @(negedge clk);
         check($sformatf("R%0d_cu_ready", k),  cu_if.req_ready, e_cr);
         check($sformatf("R%0d_dbg_ready", k), dbg_if.req_ready, e_dr);
         check($sformatf("R%0d_lock_ack", k),  dbg_lock_ack, m_locked);

         exp_v = (q_cu.size() > 0) && (q_cu[0].due == k);
         if (exp_v) begin
            e = q_cu.pop_front();
            last_cu = e.data;
         end
         check($sformatf("R%0d_cu_rsp_v", k),  cu_if.rsp_valid, exp_v);
         check($sformatf("R%0d_cu_rdata", k),  cu_if.rsp_rdata, last_cu);

         exp_v = (q_dbg.size() > 0) && (q_dbg[0].due == k);
         if (exp_v) begin
            e = q_dbg.pop_front();
            last_dbg = e.data;
         end
         check($sformatf("R%0d_dbg_rsp_v", k), dbg_if.rsp_valid, exp_v);
         check($sformatf("R%0d_dbg_rdata", k), dbg_if.rsp_rdata, last_dbg);

         acc_cu  = cv & e_cr;
         acc_dbg = dv & e_dr;
         if (acc_cu) begin
            $display("[TB] rnd %0d CU %s R%0d data=0x%02h", k, cwe ? "write" : "read", ca, cwe ? cd : m_reg[ca]);
            if (cwe) m_reg[ca] = cd;
            else begin
               e.data = m_reg[ca];
               e.due  = k + 2;
               q_cu.push_back(e);
            end
            m_last = REQ_CU;
         end
         if (acc_dbg) begin
            $display("[TB] rnd %0d DBG %s R%0d data=0x%02h", k, dwe ? "write" : "read", da, dwe ? dd : m_reg[da]);
            if (dwe) m_reg[da] = dd;
            else begin
               e.data = m_reg[da];
               e.due  = k + 2;
               q_dbg.push_back(e);
            end
            m_last = REQ_DBG;
         end
         m_locked = lk;
         next_cycle();
      end
      check("rnd_cu_rsp_outstanding",  q_cu.size(), 0);
      check("rnd_dbg_rsp_outstanding", q_dbg.size(), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
